// File: rtl/data_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_pipe
// Purpose  : Pipelined load/store data memory for the CPU data path.
//            Byte/half/word accesses, little-endian lanes, sign/zero extended
//            loads, alignment/range/size error detection, valid/ready request
//            and response handshakes, in-order responses with backpressure.
// Ports    : clk, rst                      clock, synchronous active-high reset
//            req_valid/req_ready           request handshake
//            req_we, req_size, req_sext    store flag, access size, load sign-ext
//            req_addr, req_wdata           byte address, right-justified data
//            resp_valid/resp_ready         response handshake
//            resp_rdata, resp_err          load result, error flag
// Revision : 1.0  initial release
// ============================================================================
module data_ram_pipe #(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int RESP_DEPTH = READ_LATENCY + 1;
    localparam int c_WORDS    = 1 << DEPTH_LOG2;
    localparam int c_PW       = $clog2(RESP_DEPTH + 1);
    localparam int c_FW       = $clog2(RESP_DEPTH);
    localparam logic [c_PW-1:0] c_PEND_MAX = c_PW'(RESP_DEPTH);
    localparam logic [c_FW-1:0] c_PTR_LAST = c_FW'(RESP_DEPTH - 1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  w_acc;
    logic [1:0]            w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_err;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [c_PW-1:0]       r_pend;
    logic                  w_pop;

    assign req_ready = !rst && (r_pend < c_PEND_MAX);
    assign w_acc     = req_valid && req_ready;
    assign w_off     = req_addr[1:0];
    assign w_idx     = req_addr[DEPTH_LOG2+1:2];

    assign w_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]))
                 | (|req_addr[31:DEPTH_LOG2+2]);

    // Store data is replicated across lanes so the lane enables alone
    // select which bytes land in the word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy: accepted but not yet handed over requests
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_pend <= r_pend + c_PW'(1);
                2'b01:   r_pend <= r_pend - c_PW'(1);
                default: r_pend <= r_pend;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store commit register: stores land in the array one edge after
    // acceptance. A load accepted on that same edge reads the old word,
    // so the pending lanes are forwarded into its result.
    // ------------------------------------------------------------------
    logic                  r_wr_vld;
    logic [DEPTH_LOG2-1:0] r_wr_idx;
    logic [3:0]            r_wr_be;
    logic [31:0]           r_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_vld <= 1'b0;
        end else begin
            r_wr_vld <= w_acc && req_we && !w_err;
        end
        r_wr_idx  <= w_idx;
        r_wr_be   <= w_be;
        r_wr_data <= w_wdata;
    end

    logic [31:0] r_mem [c_WORDS];
    logic [31:0] r_ram_q;
    logic [3:0]  r_fwd_be;
    logic [31:0] r_fwd_data;

    always_ff @(posedge clk) begin
        if (r_wr_vld) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wr_be[b]) begin
                    r_mem[r_wr_idx][8*b +: 8] <= r_wr_data[8*b +: 8];
                end
            end
        end
        r_ram_q    <= r_mem[w_idx];
        r_fwd_be   <= (r_wr_vld && (r_wr_idx == w_idx)) ? r_wr_be : 4'b0000;
        r_fwd_data <= r_wr_data;
    end

    // ------------------------------------------------------------------
    // Stage 1: RAM output, lane select and extension
    // ------------------------------------------------------------------
    logic       r_s1_vld;
    logic       r_s1_we;
    logic       r_s1_err;
    logic [1:0] r_s1_size;
    logic       r_s1_sext;
    logic [1:0] r_s1_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_acc;
        end
        r_s1_we   <= req_we;
        r_s1_err  <= w_err;
        r_s1_size <= req_size;
        r_s1_sext <= req_sext;
        r_s1_off  <= w_off;
    end

    logic [31:0] w_word;
    logic [15:0] w_shift;
    logic [31:0] w_ld;
    logic [31:0] w_s1_rdata;

    always_comb begin
        w_word = r_ram_q;
        for (int b = 0; b < 4; b++) begin
            if (r_fwd_be[b]) begin
                w_word[8*b +: 8] = r_fwd_data[8*b +: 8];
            end
        end
        w_shift = 16'(w_word >> {r_s1_off, 3'b000});
        case (r_s1_size)
            2'b00:   w_ld = {{24{r_s1_sext & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_ld = {{16{r_s1_sext & w_shift[15]}}, w_shift[15:0]};
            default: w_ld = w_word;
        endcase
        w_s1_rdata = (r_s1_we || r_s1_err) ? 32'h0 : w_ld;
    end

    // ------------------------------------------------------------------
    // Optional second register stage
    // ------------------------------------------------------------------
    logic        w_out_vld;
    logic [31:0] w_out_rdata;
    logic        w_out_err;

    if (READ_LATENCY == 2) begin : g_lat2
        logic        r_s2_vld;
        logic [31:0] r_s2_rdata;
        logic        r_s2_err;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_vld <= 1'b0;
            end else begin
                r_s2_vld <= r_s1_vld;
            end
            r_s2_rdata <= w_s1_rdata;
            r_s2_err   <= r_s1_err;
        end

        assign w_out_vld   = r_s2_vld;
        assign w_out_rdata = r_s2_rdata;
        assign w_out_err   = r_s2_err;
    end else begin : g_lat1
        assign w_out_vld   = r_s1_vld;
        assign w_out_rdata = w_s1_rdata;
        assign w_out_err   = r_s1_err;
    end

    // ------------------------------------------------------------------
    // Response FIFO, first-word-fall-through: when empty the pipeline
    // result is presented directly and only enters storage if it is not
    // consumed in its first cycle. The pipeline never stalls; r_pend
    // guarantees a free slot for every result.
    // ------------------------------------------------------------------
    logic [32:0]     r_fifo [RESP_DEPTH];
    logic [c_FW-1:0] r_wptr;
    logic [c_FW-1:0] r_rptr;
    logic [c_PW-1:0] r_cnt;
    logic            w_empty;
    logic            w_push;
    logic            w_fifo_pop;
    logic [32:0]     w_head;

    function automatic logic [c_FW-1:0] f_inc(input logic [c_FW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_FW'(1);
    endfunction

    assign w_empty    = (r_cnt == '0);
    assign resp_valid = !w_empty || w_out_vld;
    assign w_head     = w_empty ? {w_out_err, w_out_rdata} : r_fifo[r_rptr];
    assign w_pop      = resp_valid && resp_ready;
    assign w_push     = w_out_vld && !(w_empty && resp_ready);
    assign w_fifo_pop = w_pop && !w_empty;
    assign resp_rdata = resp_valid ? w_head[31:0] : 32'h0;
    assign resp_err   = resp_valid & w_head[32];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {w_out_err, w_out_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_fifo_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({w_push, w_fifo_pop})
                2'b10:   r_cnt <= r_cnt + c_PW'(1);
                2'b01:   r_cnt <= r_cnt - c_PW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire
